bidir_bus_master: RTL

//   Controller for the far end of the shared 8-bit tristate bus that bidirec hangs off.
//   - Owns both output enables: its own (bus_oe) and the peer's oe (peer_oe).
//   - Write: drives the bus so the peer's per-clock sampler captures the value.
//   - Read: releases the bus, enables the peer driver and samples its value.
//   - Inserts guard cycles so both ends never drive at once.
//   - Top level builds the pad as: bus = bus_oe ? bus_out : 'z; bus_in = bus.

---
 rtl/bidir_bus_master.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bidir_bus_master.sv
// Master end of a shared tristate bus: owns both output enables and sequences
// guarded write (drive) and read (peer drive + sample) transactions.
module bidir_bus_master #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned GAP    = 1,
  parameter int unsigned HOLD   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             done,
  output logic             done_write,
  output logic [WIDTH-1:0] rd_data,
  output logic             bus_oe,
  output logic [WIDTH-1:0] bus_out,
  input  logic [WIDTH-1:0] bus_in,
  output logic             peer_oe
);

  localparam int unsigned MaxHs = (HOLD > SETTLE) ? HOLD : SETTLE;
  localparam int unsigned MaxN  = (GAP > MaxHs) ? GAP : MaxHs;
  localparam int unsigned CntW  = $clog2(MaxN + 1);

  localparam logic [CntW-1:0] GapLd    = CntW'(GAP - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD - 1);
  localparam logic [CntW-1:0] SettleLd = CntW'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StPre, StDrive, StPeer, StPost} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              done_write_q, done_write_d;
  logic              bus_oe_q, bus_oe_d;
  logic [WIDTH-1:0]  bus_out_q, bus_out_d;
  logic              peer_oe_q, peer_oe_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          wdata_d = req_wdata;
          cnt_d   = GapLd;
          state_d = StPre;
        end
      end
      StPre: begin
        if (cnt_q == '0) begin
          state_d = write_q ? StDrive : StPeer;
          cnt_d   = write_q ? HoldLd : SettleLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          state_d = StPost;
          cnt_d   = GapLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPeer: begin
        if (cnt_q == '0) begin
          rd_data_d = bus_in;
          state_d   = StPost;
          cnt_d     = GapLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPost: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    // Enables are decoded from the next state so they leave flops glitch-free.
    bus_oe_d     = (state_d == StDrive);
    bus_out_d    = bus_oe_d ? wdata_d : '0;
    peer_oe_d    = (state_d == StPeer);
    done_write_d = done_d & write_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      done_write_q <= 1'b0;
      bus_oe_q     <= 1'b0;
      bus_out_q    <= '0;
      peer_oe_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      rd_data_q    <= rd_data_d;
      done_q       <= done_d;
      done_write_q <= done_write_d;
      bus_oe_q     <= bus_oe_d;
      bus_out_q    <= bus_out_d;
      peer_oe_q    <= peer_oe_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign done       = done_q;
  assign done_write = done_write_q;
  assign rd_data    = rd_data_q;
  assign bus_oe     = bus_oe_q;
  assign bus_out    = bus_out_q;
  assign peer_oe    = peer_oe_q;

endmodule
